// File: rtl/fir_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module  : fir_sample_feeder
// Brief   : Sample FIFO that streams 2-bit samples to the FIR at a paced rate,
//           then flushes the filter delay line with TAPS zero samples.
// Revision: 1.0 - initial release
// ============================================================================
module fir_sample_feeder #(
  parameter int DEPTH  = 8,
  parameter int TAPS   = 8,
  parameter int RATE_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [1:0]             wr_data,
  input  logic                   start,
  input  logic [RATE_W-1:0]      rate,
  output logic [1:0]             sample_out,
  output logic                   sample_valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FL_W  = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [RATE_W-1:0] r_rate_q, w_rate_nxt;
  logic [RATE_W-1:0] r_pace, w_pace_nxt;
  logic [FL_W-1:0]   r_flush, w_flush_nxt;
  logic              w_push, w_pop, w_emit, w_done;

  // A full FIFO refuses writes even when a pop frees a slot this cycle.
  assign w_push      = wr_en && !full;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign level       = r_count;

  always_comb begin
    w_state_nxt = r_state;
    w_rate_nxt  = r_rate_q;
    w_pace_nxt  = r_pace;
    w_flush_nxt = r_flush;
    w_pop       = 1'b0;
    w_emit      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (r_count != '0)) begin
          w_state_nxt = ST_STREAM;
          w_rate_nxt  = rate;
          w_pace_nxt  = '0;
          w_flush_nxt = '0;
        end
      end
      ST_STREAM: begin
        if (r_pace == '0) begin
          w_emit     = 1'b1;
          w_pace_nxt = r_rate_q;
          if (r_count != '0) begin
            w_pop = 1'b1;
          end else if (TAPS == 1) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            // Drained: this slot already carries the first flush zero.
            w_state_nxt = ST_FLUSH;
            w_flush_nxt = FL_W'(1);
          end
        end else begin
          w_pace_nxt = r_pace - 1'b1;
        end
      end
      ST_FLUSH: begin
        if (r_pace == '0) begin
          w_emit     = 1'b1;
          w_pace_nxt = r_rate_q;
          if (r_flush == FL_W'(TAPS - 1)) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
            w_flush_nxt = '0;
          end else begin
            w_flush_nxt = r_flush + 1'b1;
          end
        end else begin
          w_pace_nxt = r_pace - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rate_q     <= '0;
      r_pace       <= '0;
      r_flush      <= '0;
      sample_out   <= 2'b00;
      sample_valid <= 1'b0;
      full         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rate_q     <= w_rate_nxt;
      r_pace       <= w_pace_nxt;
      r_flush      <= w_flush_nxt;
      r_count      <= w_count_nxt;
      full         <= (w_count_nxt == CNT_W'(DEPTH));
      busy         <= (w_state_nxt != ST_IDLE);
      done         <= w_done;
      sample_valid <= w_emit;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_emit) sample_out <= w_pop ? r_mem[r_rd_ptr] : 2'b00;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_fir_sample_feeder
// Brief   : Self-checking bench for fir_sample_feeder (vector table, directed
//           corner cases, random traffic against a scheduling reference model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fir_sample_feeder;

  localparam int DEPTH = 8;
  localparam int TAPS  = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_data;
  logic       start;
  logic [3:0] rate;
  logic [1:0] sample_out;
  logic       sample_valid, full, busy, done;
  logic [3:0] level;

  int vectors = 0;
  int miscompares = 0;

  // reference model: queue of samples plus an absolute emission schedule
  logic [1:0] mq[$];
  bit         m_busy, m_flushing, m_valid, m_done;
  logic [1:0] m_out;
  int         m_gap, m_zeros;
  longint     cyc = 0;
  longint     m_next;

  logic [1:0] cap[$];
  int         done_at, consec, done_cnt;
  logic       prev_valid;

  typedef struct {
    logic       wr;
    logic [1:0] d;
    logic       st;
    logic [3:0] rt;
    logic       e_valid;
    logic [1:0] e_out;
    logic       e_done;
    logic       e_busy;
    logic [3:0] e_level;
  } vec_t;

  vec_t tbl[18];

  fir_sample_feeder #(.DEPTH(DEPTH), .TAPS(TAPS), .RATE_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .start       (start),
    .rate        (rate),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .full        (full),
    .level       (level),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(int wr, int d, int st, int rt, int v, int o, int dn, int b, int l);
    vec_t x;
    x.wr = wr[0]; x.d = d[1:0]; x.st = st[0]; x.rt = rt[3:0];
    x.e_valid = v[0]; x.e_out = o[1:0]; x.e_done = dn[0]; x.e_busy = b[0]; x.e_level = l[3:0];
    return x;
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_busy = 0; m_flushing = 0; m_valid = 0; m_done = 0; m_out = 2'd0;
  endfunction

  // one clock edge of the reference model, using the inputs sampled at that edge
  function automatic void m_edge();
    int pre;
    pre = mq.size();
    m_valid = 0;
    m_done  = 0;
    if (m_busy && cyc == m_next) begin
      m_valid = 1;
      m_next  = cyc + m_gap;
      if (!m_flushing && pre > 0) begin
        m_out = mq.pop_front();
      end else begin
        m_flushing = 1;
        m_out      = 2'd0;
        m_zeros--;
        if (m_zeros == 0) begin
          m_done = 1; m_busy = 0; m_flushing = 0;
        end
      end
    end else if (!m_busy && start && pre > 0) begin
      m_busy = 1; m_flushing = 0; m_next = cyc + 1;
      m_gap = int'(rate) + 1; m_zeros = TAPS;
    end
    if (wr_en && pre < DEPTH) mq.push_back(wr_data);
    cyc++;
  endfunction

  function automatic logic [15:0] dut_vec();
    return {6'd0, sample_valid, sample_out, done, busy, level, full};
  endfunction

  function automatic logic [15:0] model_vec();
    return {6'd0, m_valid, m_out, m_done, m_busy, 4'(mq.size()), (mq.size() == DEPTH)};
  endfunction

  function automatic void check(string name, logic [15:0] got, logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    end
  endfunction

  function automatic logic [1:0] capv(int k);
    logic [1:0] v;
    v = 2'bxx;
    if (k < cap.size()) v = cap[k];
    return v;
  endfunction

  task automatic step(input logic w, input logic [1:0] d, input logic s, input logic [3:0] r);
    wr_en = w; wr_data = d; start = s; rate = r;
    @(posedge clock);
    m_edge();
    #1 check($sformatf("model cyc %0d", cyc), dut_vec(), model_vec());
    @(negedge clock);
  endtask

  task automatic cap_clear();
    cap.delete(); consec = 0; done_cnt = 0; prev_valid = sample_valid;
  endtask

  task automatic cstep(input logic w, input logic [1:0] d, input logic s, input logic [3:0] r);
    step(w, d, s, r);
    if (sample_valid) begin
      if (prev_valid) consec++;
      cap.push_back(sample_out);
    end
    prev_valid = sample_valid;
    if (done) done_cnt++;
  endtask

  task automatic drain(input int budget);
    done_at = -1;
    for (int i = 1; i <= budget; i++) begin
      cstep(1'b0, 2'd0, 1'b0, 4'd0);
      if (done) begin
        done_at = i;
        break;
      end
    end
    if (done_at < 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: no done within %0d cycles, got busy=%0b expected done pulse", budget, busy);
    end
  endtask

  initial begin
    // basic stream, rate 0: hand-derived expectations per edge
    tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[1] = mk(1, 2, 0, 0, 0, 0, 0, 0, 2);
    tbl[2] = mk(1, 3, 0, 0, 0, 0, 0, 0, 3);
    tbl[3] = mk(1, 2, 0, 0, 0, 0, 0, 0, 4);
    tbl[4] = mk(0, 0, 1, 0, 0, 0, 0, 1, 4);
    tbl[5] = mk(0, 0, 0, 0, 1, 0, 0, 1, 3);
    tbl[6] = mk(0, 0, 0, 0, 1, 2, 0, 1, 2);
    tbl[7] = mk(0, 0, 0, 0, 1, 3, 0, 1, 1);
    tbl[8] = mk(0, 0, 0, 0, 1, 2, 0, 1, 0);
    for (int i = 9; i <= 15; i++) tbl[i] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 1, 0, 1, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b0; wr_en = 1'b0; wr_data = 2'd0; start = 1'b0; rate = 4'd0;
    m_reset();
    repeat (2) @(posedge clock);
    #1 check("reset state", dut_vec(), 16'd0);
    @(negedge clock);
    reset = 1'b1;

    // start with an empty FIFO does nothing
    step(1'b0, 2'd0, 1'b1, 4'd5);
    check("empty start busy", {15'd0, busy}, 16'd0);

    // reset mid-stream acts asynchronously
    step(1'b1, 2'd3, 1'b0, 4'd0);
    step(1'b1, 2'd2, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 4'd0);
    step(1'b0, 2'd0, 1'b1, 4'd1);
    step(1'b0, 2'd0, 1'b0, 4'd0);
    step(1'b0, 2'd0, 1'b0, 4'd0);
    #2 reset = 1'b0;
    #1 check("async reset outputs", {6'd0, sample_out, sample_valid, full, level, busy, done}, 16'd0);
    m_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, 2'd0, 1'b1, 4'd2);
    check("post-reset level/busy", {11'd0, level, busy}, 16'd0);

    // vector table: basic stream
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].st, tbl[i].rt);
      check($sformatf("table[%0d]", i),
            {7'd0, sample_valid, sample_out, done, busy, level},
            {7'd0, tbl[i].e_valid, tbl[i].e_out, tbl[i].e_done, tbl[i].e_busy, tbl[i].e_level});
    end

    // pacing: rate 2, two samples, done lands at E0+28
    step(1'b1, 2'd3, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 4'd0);
    cap_clear();
    cstep(1'b0, 2'd0, 1'b1, 4'd2);
    drain(100);
    check("pace done edge", 16'(done_at), 16'd28);
    check("pace strobe count", 16'(cap.size()), 16'(2 + TAPS));
    check("pace back-to-back strobes", 16'(consec), 16'd0);
    check("pace data", {12'd0, capv(0), capv(1)}, {12'd0, 2'd3, 2'd1});

    // overflow: 9th write dropped
    for (int i = 0; i < 9; i++) step(1'b1, 2'((i + 1) % 4), 1'b0, 4'd0);
    check("overflow level/full", {11'd0, level, full}, {11'd0, 4'd8, 1'b1});
    cap_clear();
    cstep(1'b0, 2'd0, 1'b1, 4'd0);
    drain(100);
    check("overflow strobe count", 16'(cap.size()), 16'(8 + TAPS));
    for (int k = 0; k < 9; k++)
      check($sformatf("overflow sample %0d", k), {14'd0, capv(k)}, (k < 8) ? 16'((k + 1) % 4) : 16'd0);

    // concurrent writes before the first pop, then start+write during flush
    step(1'b1, 2'd1, 1'b0, 4'd0);
    cap_clear();
    cstep(1'b1, 2'd2, 1'b1, 4'd3);
    cstep(1'b1, 2'd3, 1'b0, 4'd0);
    begin
      bit injected;
      injected = 0;
      for (int i = 0; i < 300 && done_cnt == 0; i++) begin
        if (!injected && cap.size() == 5) begin
          cstep(1'b1, 2'd2, 1'b1, 4'd0);
          injected = 1;
        end else begin
          cstep(1'b0, 2'd0, 1'b0, 4'd0);
        end
      end
    end
    repeat (6) cstep(1'b0, 2'd0, 1'b0, 4'd0);
    check("flush start done pulses", 16'(done_cnt), 16'd1);
    check("concurrent strobe count", 16'(cap.size()), 16'(3 + TAPS));
    check("concurrent data", {8'd0, capv(0), capv(1), capv(2), capv(3)},
          {8'd0, 2'd1, 2'd2, 2'd3, 2'd0});
    check("queued after flush", {11'd0, level, busy}, {11'd0, 4'd1, 1'b0});
    cap_clear();
    cstep(1'b0, 2'd0, 1'b1, 4'd0);
    drain(50);

    // random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      step((i < 750) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0),
           4'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
